sram_frame_writer: RTL and testbench

- Write-side counterpart of the SRAM-to-VGA frame reader.
- Accepts a 16-bit pixel stream through a valid/ready handshake and writes one full frame into the external asynchronous SRAM (1024x1024 words).
- Word format: upper byte R, lower byte B.
- While writing, drives frame_we_n low, which stalls and resets the reader's pixel/line counters. Releases the SRAM bus to read mode when the frame is complete.

---
 rtl/sram_frame_writer.sv | 175 +++++++++++++++++
 tb/tb_sram_frame_writer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_writer.sv
// Purpose: writes one frame of 16-bit pixel words (R high byte, B low byte) from a valid/ready stream into the async SRAM.
// Latency: one word per WE_CYCLES+2 clocks, plus TURN_CYCLES of bus turnaround on entry to and exit from write mode.
// Backpressure: pix_ready is high only in the ACCEPT state, so an unaccepted word must be held by the source.
module sram_frame_writer #(
    parameter int FRAME_WORDS = 1048576,
    parameter int ADDR_W      = 20,
    parameter int WE_CYCLES   = 2,
    parameter int TURN_CYCLES = 2
) (
    input  logic              clk108,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [15:0]       pix_data,
    input  logic              pix_sof,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    output logic              frame_we_n,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0]  WE_LAST   = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN_OFF,
        S_ACCEPT,
        S_STROBE,
        S_RECOVER,
        S_TURN_ON
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        dq_out_q;
    logic               dq_oe_q;
    logic               we_n_q;
    logic               oe_n_q;
    logic               pix_ready_q;
    logic               frame_we_n_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               sof_err_q;

    logic               hs_fire_d;
    logic [ADDR_W-1:0]  addr_inc_d;

    // Handshake qualifier and the next sequential address.
    always_comb begin
        hs_fire_d  = pix_valid && pix_ready_q;
        addr_inc_d = addr_q + ADDR_W'(1);
    end

    // Write sequencer: bus turnaround, per-word WE strobe, address stepping and status pulses.
    always_ff @(posedge clk108 or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            dq_out_q     <= '0;
            dq_oe_q      <= 1'b0;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b0;
            pix_ready_q  <= 1'b0;
            frame_we_n_q <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        state_q      <= S_TURN_OFF;
                        frame_we_n_q <= 1'b0;
                        busy_q       <= 1'b1;
                        addr_q       <= '0;
                        cnt_q        <= '0;
                    end
                end
                S_TURN_OFF: begin
                    // Reader side lets go of the pads before this block drives them.
                    oe_n_q <= 1'b1;
                    if (cnt_q == TURN_LAST) begin
                        cnt_q       <= '0;
                        pix_ready_q <= 1'b1;
                        state_q     <= S_ACCEPT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_ACCEPT: begin
                    if (hs_fire_d) begin
                        dq_out_q    <= pix_data;
                        dq_oe_q     <= 1'b1;
                        pix_ready_q <= 1'b0;
                        we_n_q      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_STROBE;
                        // Start-of-frame marker forces a resync to address 0.
                        if (pix_sof) begin
                            addr_q <= '0;
                            if (addr_q != '0) begin
                                sof_err_q <= 1'b1;
                            end
                        end
                    end
                end
                S_STROBE: begin
                    if (cnt_q == WE_LAST) begin
                        we_n_q  <= 1'b1;
                        state_q <= S_RECOVER;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RECOVER: begin
                    // Address and data held one cycle past WE rising for hold time.
                    if (addr_q == LAST_ADDR) begin
                        cnt_q   <= '0;
                        state_q <= S_TURN_ON;
                    end else begin
                        addr_q      <= addr_inc_d;
                        pix_ready_q <= 1'b1;
                        state_q     <= S_ACCEPT;
                    end
                end
                S_TURN_ON: begin
                    dq_oe_q <= 1'b0;
                    if (cnt_q == TURN_LAST) begin
                        oe_n_q       <= 1'b0;
                        frame_we_n_q <= 1'b1;
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pix_ready   = pix_ready_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_ce_n   = 1'b0;
    assign sram_ub_n   = 1'b0;
    assign sram_lb_n   = 1'b0;
    assign frame_we_n  = frame_we_n_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign sof_err     = sof_err_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Purpose: directed bench for sram_frame_writer with a 4-word and a 16-word frame instance sharing the pixel source.
// Latency: handshake spacing, WE pulse width and frame_done timing are checked against hand-derived cycle counts.
// Backpressure: the source holds its word while valid and not ready, and puts junk on the bus only while valid is low.
module tb_sram_frame_writer;

    localparam int TURN = 2;

    typedef struct {
        logic [15:0] dat;
        logic        sof;
        int          exp_addr;
        int          exp_err;
    } vec_t;

    typedef struct {
        int k;
        int addr;
        int dat;
        int len;
    } log_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs    [2];
    logic        pv;
    logic [15:0] pd;
    logic        ps;

    logic        rdy   [2];
    logic [19:0] addr  [2];
    logic [15:0] dq    [2];
    logic        dqoe  [2];
    logic        we_n  [2];
    logic        oe_n  [2];
    logic        ce_n  [2];
    logic        ub_n  [2];
    logic        lb_n  [2];
    logic        fwe_n [2];
    logic        busy  [2];
    logic        done  [2];
    logic        serr  [2];

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    vec_t        vec [26];
    log_t        wlog [$];
    logic [15:0] mem [2][16];
    logic        prev_we [2];
    logic [19:0] lat_a [2];
    logic [15:0] lat_d [2];
    int          lo_len [2];
    int          viol [2];
    int          done_cnt [2];
    int          serr_cnt [2];
    int          last_rec = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_frame_writer #(.FRAME_WORDS(4), .ADDR_W(20), .WE_CYCLES(2), .TURN_CYCLES(TURN)) u_dut4 (
        .clk108(clk), .rst(rst_n), .frame_start(fs[0]), .pix_valid(pv), .pix_ready(rdy[0]),
        .pix_data(pd), .pix_sof(ps), .sram_addr(addr[0]), .sram_dq_out(dq[0]), .sram_dq_oe(dqoe[0]),
        .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]), .sram_ce_n(ce_n[0]), .sram_ub_n(ub_n[0]),
        .sram_lb_n(lb_n[0]), .frame_we_n(fwe_n[0]), .busy(busy[0]), .frame_done(done[0]), .sof_err(serr[0])
    );

    sram_frame_writer #(.FRAME_WORDS(16), .ADDR_W(20), .WE_CYCLES(2), .TURN_CYCLES(TURN)) u_dut16 (
        .clk108(clk), .rst(rst_n), .frame_start(fs[1]), .pix_valid(pv), .pix_ready(rdy[1]),
        .pix_data(pd), .pix_sof(ps), .sram_addr(addr[1]), .sram_dq_out(dq[1]), .sram_dq_oe(dqoe[1]),
        .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]), .sram_ce_n(ce_n[1]), .sram_ub_n(ub_n[1]),
        .sram_lb_n(lb_n[1]), .frame_we_n(fwe_n[1]), .busy(busy[1]), .frame_done(done[1]), .sof_err(serr[1])
    );

    // SRAM model: a write lands when WE rises; also watches bus contention and address/data stability.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                prev_we[k] = 1'b1;
            end else begin
                if (dqoe[k] && !oe_n[k]) viol[k]++;
                if (!we_n[k]) begin
                    if (prev_we[k]) begin
                        lat_a[k]  = addr[k];
                        lat_d[k]  = dq[k];
                        lo_len[k] = 0;
                    end else if (addr[k] != lat_a[k] || dq[k] != lat_d[k]) begin
                        viol[k]++;
                    end
                    if (!dqoe[k]) viol[k]++;
                    lo_len[k]++;
                end else if (!prev_we[k]) begin
                    log_t e;
                    e.k    = k;
                    e.addr = int'(lat_a[k]);
                    e.dat  = int'(lat_d[k]);
                    e.len  = lo_len[k];
                    wlog.push_back(e);
                    mem[k][lat_a[k][3:0]] = lat_d[k];
                    last_rec = cyc;
                end
                if (done[k]) done_cnt[k]++;
                if (serr[k]) serr_cnt[k]++;
                prev_we[k] = we_n[k];
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Offers one word until it is accepted; call and return #1 after a rising edge.
    task automatic send(input int k, input int idx, input bit rnd, output int hs_cyc, output bit ok);
        int budget;
        budget = 200;
        ok     = 1'b0;
        hs_cyc = 0;
        while (budget > 0) begin
            if (rnd && $urandom_range(0, 1) == 0) begin
                pv = 1'b0;
                pd = 16'hDEAD;
            end else begin
                pv = 1'b1;
                pd = vec[idx].dat;
            end
            ps = vec[idx].sof;
            @(negedge clk);
            if (pv && rdy[k]) begin
                @(posedge clk);
                hs_cyc = cyc;
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            budget--;
        end
    endtask

    task automatic run_frame(input int k, input int first, input int n, input bit rnd,
                             input bit poke, input bit spacing, input int exp_serr);
        int  hs, prev_hs, b;
        bit  ok, got;
        logic prev_fwe;
        wlog.delete();
        done_cnt[k] = 0;
        serr_cnt[k] = 0;
        prev_hs     = 0;
        @(posedge clk); #1;
        fs[k] = 1'b1;
        @(posedge clk); #1;
        fs[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (poke && i == 2) begin
                pv = 1'b0;
                b  = 0;
                @(negedge clk);
                while (!rdy[k] && b < 50) begin
                    @(negedge clk);
                    b++;
                end
                chk("poke_in_accept", int'(rdy[k]), 1);
                fs[k] = 1'b1;
                @(posedge clk); #1;
                fs[k] = 1'b0;
            end
            send(k, first + i, rnd, hs, ok);
            chk("handshake", int'(ok), 1);
            chk("sof_err", int'(serr[k]), vec[first + i].exp_err);
            if (i == 0) begin
                chk("frame_we_n_writing", int'(fwe_n[k]), 0);
                chk("busy_writing", int'(busy[k]), 1);
            end
            if (spacing && i > 0) chk("hs_spacing", hs - prev_hs, 4);
            prev_hs = hs;
        end
        pv = 1'b0;
        ps = 1'b0;
        got      = 1'b0;
        prev_fwe = fwe_n[k];
        b        = 0;
        while (b < 100 && !got) begin
            @(negedge clk);
            if (done[k]) begin
                got = 1'b1;
                chk("done_after_recover", cyc - last_rec, TURN + 1);
                chk("frame_we_n_at_done", int'(fwe_n[k]), 1);
                chk("frame_we_n_before_done", int'(prev_fwe), 0);
                chk("busy_at_done", int'(busy[k]), 0);
            end else begin
                prev_fwe = fwe_n[k];
            end
            b++;
        end
        chk("frame_done_seen", int'(got), 1);
        repeat (6) @(negedge clk);
        chk("done_count", done_cnt[k], 1);
        chk("sof_err_count", serr_cnt[k], exp_serr);
        chk("idle_after_frame", int'(busy[k]), 0);
        chk("write_count", wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            chk("wr_addr", wlog[i].addr, vec[first + i].exp_addr);
            chk("wr_data", wlog[i].dat, int'(vec[first + i].dat));
            chk("we_low_len", wlog[i].len, 2);
        end
    endtask

    initial begin
        int  hs;
        bit  ok;
        rst_n = 1'b0;
        fs[0] = 1'b0;
        fs[1] = 1'b0;
        pv    = 1'b0;
        pd    = 16'h0000;
        ps    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            viol[k]     = 0;
            done_cnt[k] = 0;
            serr_cnt[k] = 0;
            prev_we[k]  = 1'b1;
            lo_len[k]   = 0;
        end

        // 4-word frame, sof on first word
        vec[0] = '{16'h1111, 1'b1, 0, 0};
        vec[1] = '{16'h2222, 1'b0, 1, 0};
        vec[2] = '{16'h3333, 1'b0, 2, 0};
        vec[3] = '{16'h4444, 1'b0, 3, 0};
        // sof repeated on the third word forces a resync to address 0
        vec[4] = '{16'hA001, 1'b1, 0, 0};
        vec[5] = '{16'hA002, 1'b0, 1, 0};
        vec[6] = '{16'hA003, 1'b1, 0, 1};
        vec[7] = '{16'hA004, 1'b0, 1, 0};
        vec[8] = '{16'hA005, 1'b0, 2, 0};
        vec[9] = '{16'hA006, 1'b0, 3, 0};
        // 16-word frame
        for (int i = 0; i < 16; i++) begin
            vec[10 + i] = '{16'h5A00 | 16'(i), (i == 0), i, 0};
        end

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_oe_n", int'(oe_n[0]), 0);
        chk("rst_we_n", int'(we_n[0]), 1);
        chk("rst_frame_we_n", int'(fwe_n[0]), 1);
        chk("rst_pix_ready", int'(rdy[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_dq_oe", int'(dqoe[0]), 0);
        chk("rst_addr", int'(addr[0]), 0);
        chk("rst_ce_ub_lb", int'({ce_n[0], ub_n[0], lb_n[0]}), 0);
        chk("rst_done_16", int'(done[1]), 0);

        run_frame(0, 0, 4, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) chk("mem4", int'(mem[0][i]), int'(vec[i].dat));

        run_frame(0, 4, 6, 1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 4; i++) chk("mem_resync", int'(mem[0][i]), int'(vec[6 + i].dat));

        run_frame(0, 0, 4, 1'b0, 1'b1, 1'b0, 0);

        run_frame(1, 10, 16, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 16; i++) chk("mem16", int'(mem[1][i]), int'(vec[10 + i].dat));

        // Reset during the strobe of the word at address 5
        wlog.delete();
        done_cnt[1] = 0;
        @(posedge clk); #1;
        fs[1] = 1'b1;
        @(posedge clk); #1;
        fs[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(1, 10 + i, 1'b0, hs, ok);
            chk("pre_rst_handshake", int'(ok), 1);
        end
        chk("pre_rst_addr", int'(addr[1]), 5);
        chk("pre_rst_we_n", int'(we_n[1]), 0);
        pv    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", int'(we_n[1]), 1);
        chk("mid_rst_dq_oe", int'(dqoe[1]), 0);
        chk("mid_rst_frame_we_n", int'(fwe_n[1]), 1);
        chk("mid_rst_busy", int'(busy[1]), 0);
        chk("mid_rst_oe_n", int'(oe_n[1]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_rst", done_cnt[1], 0);
        chk("idle_after_rst", int'(busy[1]), 0);

        run_frame(1, 10, 16, 1'b1, 1'b0, 1'b0, 0);

        chk("bus_rules_4", viol[0], 0);
        chk("bus_rules_16", viol[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
